// File: rtl/alu_pkg.sv
// Shared definitions for the serial ALU sequencer:
// opcodes, FSM states, flags-byte layout, opcode check.
package alu_pkg;

  localparam int NB_OP_DEF = 6;

  localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP_DEF-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'b000010;

  localparam int FLG_OVF  = 1;
  localparam int FLG_ZERO = 0;

  typedef enum logic [2:0] {
    ST_WAIT_A,
    ST_WAIT_B,
    ST_WAIT_OP,
    ST_EXEC,
    ST_TX_RES,
    ST_TX_RES_WAIT,
    ST_TX_FLG,
    ST_TX_FLG_WAIT
  } state_t;

  function automatic logic op_valid(
    input logic [NB_OP_DEF-1:0] op
  );
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL:
        op_valid = 1'b1;
      default:
        op_valid = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_timeout.sv
// Inter-byte idle counter: i_clear, i_enable in,
// o_expired pulses on the idle cycle reaching TIMEOUT_CYCLES-1.
module seq_timeout_counter import alu_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int NB_CNT =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [NB_CNT-1:0] LAST =
    NB_CNT'(TIMEOUT_CYCLES - 2);

  logic [NB_CNT-1:0] cnt;

  // Fires on the idle cycle whose increment would
  // bring the count to TIMEOUT_CYCLES-1.
  assign o_expired = i_enable && (cnt == LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      cnt <= '0;
    else if (i_clear || o_expired)
      cnt <= '0;
    else if (i_enable)
      cnt <= cnt + NB_CNT'(1);
  end

endmodule

// File: rtl/alu_sequencer.sv
// Collects A, B, opcode bytes from RX, drives the ALU,
// returns result then flags on TX. Busy/error/timeout out.
module alu_sequencer import alu_pkg::*; #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = NB_OP_DEF,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_alu_overflow,
  input  logic               i_alu_zero,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op_code,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_op_error,
  output logic               o_timeout
);

  state_t state;
  state_t state_nxt;

  logic               in_rx_wait;
  logic               tmo_clear;
  logic               tmo_en;
  logic               tmo_exp;
  logic               opv;
  logic [NB_DATA-1:0] flags;

  assign in_rx_wait = (state == ST_WAIT_B) ||
                      (state == ST_WAIT_OP);
  assign tmo_en     = in_rx_wait && !i_rx_done;
  assign tmo_clear  = !in_rx_wait || i_rx_done;
  assign opv        =
    op_valid(NB_OP_DEF'(i_rx_data[NB_OP-1:0]));

  seq_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_clear  (tmo_clear),
    .i_enable (tmo_en),
    .o_expired(tmo_exp)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      state <= ST_WAIT_A;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_WAIT_A:
        if (i_rx_done) state_nxt = ST_WAIT_B;
      ST_WAIT_B:
        if (i_rx_done)    state_nxt = ST_WAIT_OP;
        else if (tmo_exp) state_nxt = ST_WAIT_A;
      ST_WAIT_OP:
        if (i_rx_done) begin
          if (opv) state_nxt = ST_EXEC;
        end else if (tmo_exp) begin
          state_nxt = ST_WAIT_A;
        end
      ST_EXEC:
        state_nxt = ST_TX_RES;
      ST_TX_RES:
        state_nxt = ST_TX_RES_WAIT;
      ST_TX_RES_WAIT:
        if (i_tx_done) state_nxt = ST_TX_FLG;
      ST_TX_FLG:
        state_nxt = ST_TX_FLG_WAIT;
      ST_TX_FLG_WAIT:
        if (i_tx_done) state_nxt = ST_WAIT_A;
      default:
        state_nxt = ST_WAIT_A;
    endcase
  end

  // The result is captured straight into o_tx_data so
  // it is already valid in the cycle o_tx_start is high.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_data_a   <= '0;
      o_data_b   <= '0;
      o_op_code  <= '0;
      o_tx_data  <= '0;
      o_op_error <= 1'b0;
      o_timeout  <= 1'b0;
      flags      <= '0;
    end else begin
      o_op_error <= 1'b0;
      o_timeout  <= 1'b0;
      unique case (state)
        ST_WAIT_A:
          if (i_rx_done) o_data_a <= i_rx_data;
        ST_WAIT_B:
          if (i_rx_done)    o_data_b  <= i_rx_data;
          else if (tmo_exp) o_timeout <= 1'b1;
        ST_WAIT_OP:
          if (i_rx_done) begin
            if (opv)
              o_op_code <= i_rx_data[NB_OP-1:0];
            else
              o_op_error <= 1'b1;
          end else if (tmo_exp) begin
            o_timeout <= 1'b1;
          end
        ST_EXEC: begin
          o_tx_data       <= i_alu_result;
          flags           <= '0;
          flags[FLG_OVF]  <= i_alu_overflow;
          flags[FLG_ZERO] <= i_alu_zero;
        end
        ST_TX_RES_WAIT:
          if (i_tx_done) o_tx_data <= flags;
        default: ;
      endcase
    end
  end

  always_comb begin
    o_tx_start = (state == ST_TX_RES) ||
                 (state == ST_TX_FLG);
    o_busy     = (state != ST_WAIT_A);
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer
// against a byte-level command/response model.
module tb_alu_sequencer;

  localparam int TMO = 16;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic       i_tx_done;
  logic [7:0] i_alu_result;
  logic       i_alu_overflow;
  logic       i_alu_zero;
  logic [7:0] o_data_a;
  logic [7:0] o_data_b;
  logic [5:0] o_op_code;
  logic [7:0] o_tx_data;
  logic       o_tx_start;
  logic       o_busy;
  logic       o_op_error;
  logic       o_timeout;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_a;
  logic [7:0] exp_b;
  logic [5:0] exp_op;
  logic [9:0] alu_out;

  logic [5:0] valid_ops [8] = '{
    6'h20, 6'h22, 6'h24, 6'h25,
    6'h26, 6'h27, 6'h03, 6'h02
  };

  alu_sequencer #(
    .NB_DATA(8),
    .NB_OP(6),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_rx_data     (i_rx_data),
    .i_rx_done     (i_rx_done),
    .i_tx_done     (i_tx_done),
    .i_alu_result  (i_alu_result),
    .i_alu_overflow(i_alu_overflow),
    .i_alu_zero    (i_alu_zero),
    .o_data_a      (o_data_a),
    .o_data_b      (o_data_b),
    .o_op_code     (o_op_code),
    .o_tx_data     (o_tx_data),
    .o_tx_start    (o_tx_start),
    .o_busy        (o_busy),
    .o_op_error    (o_op_error),
    .o_timeout     (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  // {overflow, zero, result}
  function automatic logic [9:0] alu_ref(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [5:0] op
  );
    int s;
    logic [7:0] r;
    logic v;
    v = 1'b0;
    r = 8'h00;
    case (op)
      6'h20: begin
        s = int'($signed(a)) + int'($signed(b));
        r = 8'(s);
        v = (s > 127) || (s < -128);
      end
      6'h22: begin
        s = int'($signed(a)) - int'($signed(b));
        r = 8'(s);
        v = (s > 127) || (s < -128);
      end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h03: r = 8'($signed(a) >>> b);
      6'h02: r = a >> b;
      default: r = 8'h00;
    endcase
    return {v, (r == 8'h00), r};
  endfunction

  function automatic logic is_valid(
    input logic [5:0] op
  );
    for (int i = 0; i < 8; i++)
      if (valid_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  always_comb
    alu_out = alu_ref(o_data_a, o_data_b, o_op_code);
  assign i_alu_result   = alu_out[7:0];
  assign i_alu_zero     = alu_out[8];
  assign i_alu_overflow = alu_out[9];

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rx(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    tick();
    i_rx_done = 1'b0;
    i_rx_data = 8'($urandom);
  endtask

  task automatic tx_ack();
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"},   32'(o_data_a),   0);
    chk({tag, "_b"},   32'(o_data_b),   0);
    chk({tag, "_op"},  32'(o_op_code),  0);
    chk({tag, "_txd"}, 32'(o_tx_data),  0);
    chk({tag, "_txs"}, 32'(o_tx_start), 0);
    chk({tag, "_bsy"}, 32'(o_busy),     0);
    chk({tag, "_err"}, 32'(o_op_error), 0);
    chk({tag, "_tmo"}, 32'(o_timeout),  0);
  endtask

  task automatic send_ab(
    input logic [7:0] a,
    input logic [7:0] b,
    input int         gap
  );
    rx(a);
    exp_a = a;
    chk("busy_a", 32'(o_busy), 1);
    chk("data_a", 32'(o_data_a), 32'(a));
    idle(gap);
    rx(b);
    exp_b = b;
    chk("data_b", 32'(o_data_b), 32'(b));
    chk("keep_a", 32'(o_data_a), 32'(a));
    idle(gap);
  endtask

  task automatic send_bad(input logic [7:0] op);
    rx(op);
    chk("op_err", 32'(o_op_error), 1);
    chk("op_hold", 32'(o_op_code), 32'(exp_op));
    tick();
    chk("op_err_1cyc", 32'(o_op_error), 0);
    chk("bad_nostart", 32'(o_tx_start), 0);
    chk("bad_busy", 32'(o_busy), 1);
  endtask

  // Opcode through both TX bytes, with noise on rx.
  task automatic send_op(
    input logic [7:0] op,
    input int         d1,
    input int         d2
  );
    logic [9:0] r;
    r = alu_ref(exp_a, exp_b, op[5:0]);
    rx(op);
    exp_op = op[5:0];
    chk("op_code", 32'(o_op_code), 32'(exp_op));
    chk("exec_nostart", 32'(o_tx_start), 0);
    tick();
    chk("start_res", 32'(o_tx_start), 1);
    chk("tx_res", 32'(o_tx_data), 32'(r[7:0]));
    tick();
    chk("res_1cyc", 32'(o_tx_start), 0);
    for (int i = 0; i < d1; i++) begin
      i_rx_done = 1'($urandom);
      tick();
      i_rx_done = 1'b0;
      chk("res_hold", 32'(o_tx_data), 32'(r[7:0]));
      chk("res_wait", 32'(o_tx_start), 0);
      chk("rx_ign_a", 32'(o_data_a), 32'(exp_a));
    end
    tx_ack();
    chk("start_flg", 32'(o_tx_start), 1);
    chk("tx_flg", 32'(o_tx_data),
        32'({6'b0, r[9:8]}));
    tick();
    chk("flg_1cyc", 32'(o_tx_start), 0);
    chk("flg_busy", 32'(o_busy), 1);
    idle(d2);
    tx_ack();
    chk("done_idle", 32'(o_busy), 0);
    chk("done_nostart", 32'(o_tx_start), 0);
    chk("rx_ign_b", 32'(o_data_b), 32'(exp_b));
  endtask

  task automatic to_res_wait(
    input logic [7:0] a,
    input logic [7:0] b
  );
    send_ab(a, b, 0);
    send_op_head(8'h20);
  endtask

  task automatic send_op_head(input logic [7:0] op);
    rx(op);
    exp_op = op[5:0];
    tick();
    chk("hd_start", 32'(o_tx_start), 1);
    tick();
    idle(2);
    chk("hd_wait", 32'(o_busy), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] b;
    i_reset   = 1'b1;
    i_rx_data = 8'h00;
    i_rx_done = 1'b0;
    i_tx_done = 1'b0;
    exp_a  = 8'h00;
    exp_b  = 8'h00;
    exp_op = 6'h00;
    idle(2);
    chk_zero("rst");
    i_reset = 1'b0;
    tick();
    chk_zero("post_rst");

    send_ab(8'h05, 8'h03, 1);
    send_op(8'h20, 2, 1);
    send_ab(8'h05, 8'h05, 0);
    send_op(8'h22, 0, 0);
    send_ab(8'h7F, 8'h01, 2);
    send_op(8'h20, 3, 2);
    send_ab(8'h0A, 8'h02, 1);
    send_bad(8'h3F);
    send_op(8'h24, 1, 1);

    // Timeout in WAIT_B after TMO-1 idle cycles.
    rx(8'h11);
    exp_a = 8'h11;
    for (int i = 1; i < TMO; i++) begin
      tick();
      chk("tmo_b", 32'(o_timeout), 32'(i == TMO - 1));
    end
    chk("tmo_idle", 32'(o_busy), 0);
    chk("tmo_keep_a", 32'(o_data_a), 32'h11);
    tick();
    chk("tmo_1cyc", 32'(o_timeout), 0);

    // Byte on the expiry cycle wins.
    rx(8'h33);
    exp_a = 8'h33;
    for (int i = 1; i < TMO - 1; i++) begin
      tick();
      chk("tmo_pre", 32'(o_timeout), 0);
    end
    rx(8'h22);
    exp_b = 8'h22;
    chk("tmo_race", 32'(o_timeout), 0);
    chk("race_busy", 32'(o_busy), 1);
    chk("race_b", 32'(o_data_b), 32'h22);
    send_op(8'h20, 0, 0);

    // Timeout in WAIT_OP.
    send_ab(8'h44, 8'h55, 0);
    for (int i = 1; i < TMO; i++) begin
      tick();
      chk("tmo_op", 32'(o_timeout), 32'(i == TMO - 1));
    end
    chk("tmo_op_idle", 32'(o_busy), 0);
    chk("tmo_op_keep", 32'(o_data_b), 32'h55);

    // Reset during TX_RES_WAIT, edge aligned.
    to_res_wait(8'h12, 8'h34);
    i_reset = 1'b1;
    #1;
    chk_zero("rst_tx");
    tick();
    i_reset = 1'b0;
    exp_a  = 8'h00;
    exp_b  = 8'h00;
    exp_op = 6'h00;
    tx_ack();
    chk("late_ack_txs", 32'(o_tx_start), 0);
    chk("late_ack_bsy", 32'(o_busy), 0);
    tick();
    chk("late_ack_txs2", 32'(o_tx_start), 0);

    // Reset mid-cycle.
    to_res_wait(8'h21, 8'h43);
    #3;
    i_reset = 1'b1;
    #1;
    chk_zero("rst_mid");
    tick();
    i_reset = 1'b0;
    tx_ack();
    chk("late_ack2", 32'(o_tx_start), 0);
    send_ab(8'h09, 8'h06, 0);
    send_op(8'h26, 1, 0);

    for (int n = 0; n < 40; n++) begin
      a = 8'($urandom);
      b = (n % 3 == 0) ? 8'($urandom_range(0, 9))
                       : 8'($urandom);
      send_ab(a, b, $urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) begin
        do op = 8'($urandom);
        while (is_valid(op[5:0]));
        send_bad(op);
        idle($urandom_range(0, 5));
      end
      op = {2'($urandom),
            valid_ops[$urandom_range(0, 7)]};
      send_op(op, $urandom_range(0, 4),
              $urandom_range(0, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
